// File: rtl/raster_pkg.sv
// Types and widths shared by the triangle dispatcher, its cull stage and the rasterizer.
package raster_pkg;

  localparam int RASTER_VERTEX_WIDTH = 12;
  // Wide enough that the signed-area cross product can never overflow.
  localparam int RASTER_AREA_WIDTH   = 2 * RASTER_VERTEX_WIDTH + 2;

  typedef enum logic [3:0] {
    StIdle,
    StFetchIdx,
    StWaitIdx,
    StV0,
    StV1,
    StV2,
    StVl,
    StCull,
    StLaunch,
    StWaitDone,
    StNext,
    StFinish
  } dispatch_state_e;

  typedef struct packed {
    logic signed [RASTER_VERTEX_WIDTH-1:0] y;
    logic signed [RASTER_VERTEX_WIDTH-1:0] x;
  } vertex_t;

  function automatic logic signed [RASTER_AREA_WIDTH-1:0] sext_coord(
    input logic signed [RASTER_VERTEX_WIDTH-1:0] c
  );
    return {{(RASTER_AREA_WIDTH - RASTER_VERTEX_WIDTH){c[RASTER_VERTEX_WIDTH-1]}}, c};
  endfunction

endpackage

// File: rtl/triangle_cull.sv
// Combinational triangle cull: degenerate, optionally back-facing, or entirely off one
// framebuffer edge.
module triangle_cull
  import raster_pkg::*;
#(
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int CULL_BACKFACE = 1
) (
  input  vertex_t v0,
  input  vertex_t v1,
  input  vertex_t v2,
  output logic    cull
);

  localparam int AW = RASTER_AREA_WIDTH;
  localparam logic signed [AW-1:0] XMax = AW'(FB_WIDTH - 1);
  localparam logic signed [AW-1:0] YMax = AW'(FB_HEIGHT - 1);

  logic signed [AW-1:0] x0e, y0e, x1e, y1e, x2e, y2e;
  logic signed [AW-1:0] area;
  logic                 degenerate, back_facing, off_screen;

  always_comb begin
    x0e = sext_coord(v0.x);
    y0e = sext_coord(v0.y);
    x1e = sext_coord(v1.x);
    y1e = sext_coord(v1.y);
    x2e = sext_coord(v2.x);
    y2e = sext_coord(v2.y);

    area = (x1e - x0e) * (y2e - y0e) - (x2e - x0e) * (y1e - y0e);

    degenerate  = (area == '0);
    back_facing = (CULL_BACKFACE != 0) && area[AW-1];
    off_screen  = (x0e[AW-1] && x1e[AW-1] && x2e[AW-1]) ||
                  (y0e[AW-1] && y1e[AW-1] && y2e[AW-1]) ||
                  ((x0e > XMax) && (x1e > XMax) && (x2e > XMax)) ||
                  ((y0e > YMax) && (y1e > YMax) && (y2e > YMax));

    cull = degenerate || back_facing || off_screen;
  end

endmodule

// File: rtl/triangle_dispatcher.sv
// Walks an indexed triangle list, culls what cannot be drawn and hands the rest to the
// rasterizer one at a time, holding it in reset between triangles.
module triangle_dispatcher
  import raster_pkg::*;
#(
  parameter int VERTEX_WIDTH   = RASTER_VERTEX_WIDTH,
  parameter int IDX_WIDTH      = 8,
  parameter int TRI_ADDR_WIDTH = 8,
  parameter int FB_WIDTH       = 160,
  parameter int FB_HEIGHT      = 120,
  parameter int CULL_BACKFACE  = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [TRI_ADDR_WIDTH:0]        num_triangles,
  output logic [TRI_ADDR_WIDTH-1:0]      idx_addr,
  input  logic [3*IDX_WIDTH-1:0]         idx_data,
  output logic [IDX_WIDTH-1:0]           vtx_addr,
  input  logic [2*VERTEX_WIDTH-1:0]      vtx_data,
  output logic signed [VERTEX_WIDTH-1:0] x0,
  output logic signed [VERTEX_WIDTH-1:0] y0,
  output logic signed [VERTEX_WIDTH-1:0] x1,
  output logic signed [VERTEX_WIDTH-1:0] y1,
  output logic signed [VERTEX_WIDTH-1:0] x2,
  output logic signed [VERTEX_WIDTH-1:0] y2,
  output logic                           rast_rst,
  input  logic                           rast_done,
  output logic                           busy,
  output logic                           done,
  output logic [TRI_ADDR_WIDTH:0]        tri_drawn,
  output logic [TRI_ADDR_WIDTH:0]        tri_culled
);

  localparam int CW = TRI_ADDR_WIDTH + 1;

  dispatch_state_e             state_q, state_d;
  logic [CW-1:0]               num_q, drawn_q, culled_q;
  logic [TRI_ADDR_WIDTH-1:0]   tri_idx_q;
  logic [3*IDX_WIDTH-1:0]      idx_q;
  vertex_t                     v0_q, v1_q, v2_q;
  vertex_t                     o0_q, o1_q, o2_q;
  logic                        rast_rst_q, busy_q, done_q;
  logic                        cull, last_tri;

  triangle_cull #(
    .FB_WIDTH      (FB_WIDTH),
    .FB_HEIGHT     (FB_HEIGHT),
    .CULL_BACKFACE (CULL_BACKFACE)
  ) u_cull (
    .v0   (v0_q),
    .v1   (v1_q),
    .v2   (v2_q),
    .cull (cull)
  );

  assign last_tri = ({1'b0, tri_idx_q} == (num_q - CW'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Vertex addresses go out one per cycle; each read lands a cycle later.
  always_comb begin
    state_d  = state_q;
    vtx_addr = '0;
    unique case (state_q)
      StIdle:     if (start) state_d = (num_triangles == '0) ? StFinish : StFetchIdx;
      StFetchIdx: state_d = StWaitIdx;
      StWaitIdx:  state_d = StV0;
      StV0: begin
        vtx_addr = idx_q[IDX_WIDTH-1:0];
        state_d  = StV1;
      end
      StV1: begin
        vtx_addr = idx_q[2*IDX_WIDTH-1:IDX_WIDTH];
        state_d  = StV2;
      end
      StV2: begin
        vtx_addr = idx_q[3*IDX_WIDTH-1:2*IDX_WIDTH];
        state_d  = StVl;
      end
      StVl:       state_d = StCull;
      StCull:     state_d = cull ? StNext : StLaunch;
      StLaunch:   state_d = StWaitDone;
      StWaitDone: if (rast_done) state_d = StNext;
      StNext:     state_d = last_tri ? StFinish : StFetchIdx;
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_q      <= '0;
      drawn_q    <= '0;
      culled_q   <= '0;
      tri_idx_q  <= '0;
      idx_q      <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      o0_q       <= '0;
      o1_q       <= '0;
      o2_q       <= '0;
      rast_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == StFinish);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_q     <= num_triangles;
            tri_idx_q <= '0;
            drawn_q   <= '0;
            culled_q  <= '0;
            busy_q    <= 1'b1;
          end
        end
        StWaitIdx: idx_q <= idx_data;
        StV1:      v0_q  <= vertex_t'(vtx_data);
        StV2:      v1_q  <= vertex_t'(vtx_data);
        StVl:      v2_q  <= vertex_t'(vtx_data);
        StCull: begin
          if (cull) begin
            culled_q <= culled_q + CW'(1);
          end else begin
            o0_q    <= v0_q;
            o1_q    <= v1_q;
            o2_q    <= v2_q;
            drawn_q <= drawn_q + CW'(1);
          end
        end
        StLaunch:   rast_rst_q <= 1'b0;
        StWaitDone: if (rast_done) rast_rst_q <= 1'b1;
        StNext:     if (!last_tri) tri_idx_q <= tri_idx_q + TRI_ADDR_WIDTH'(1);
        StFinish:   busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign idx_addr   = tri_idx_q;
  assign x0         = o0_q.x;
  assign y0         = o0_q.y;
  assign x1         = o1_q.x;
  assign y1         = o1_q.y;
  assign x2         = o2_q.x;
  assign y2         = o2_q.y;
  assign rast_rst   = rast_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tri_drawn  = drawn_q;
  assign tri_culled = culled_q;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Bench for triangle_dispatcher: directed lists plus random lists against a list-level model,
// and a standalone check of triangle_cull with and without back-face culling.
module tb_triangle_dispatcher;
  import raster_pkg::*;

  localparam int VW = 12, IW = 8, TAW = 8, FBW = 160, FBH = 120, TIMEOUT = 4000;

  logic                 clk, rstn, start;
  logic [TAW:0]         num_triangles;
  logic [TAW-1:0]       idx_addr;
  logic [3*IW-1:0]      idx_data;
  logic [IW-1:0]        vtx_addr;
  logic [2*VW-1:0]      vtx_data;
  logic signed [VW-1:0] x0, y0, x1, y1, x2, y2;
  logic                 rast_rst, rast_done, busy, done;
  logic [TAW:0]         tri_drawn, tri_culled;

  logic [3*IW-1:0] idx_mem [256];
  logic [2*VW-1:0] vtx_mem [256];

  int n_cmp = 0, n_err = 0;
  int rast_lat, r_cnt;
  int done_cnt, stable_err, low_cnt, lat_d;
  logic prev_rst = 1'b1;
  logic [71:0] launches [$];
  logic [71:0] exp_q [$];
  int lows [$];
  int idx_log [$];
  int exp_drawn, exp_culled;

  vertex_t cv0, cv1, cv2;
  logic    cull_bf, cull_nbf;

  triangle_dispatcher #(
    .VERTEX_WIDTH(VW), .IDX_WIDTH(IW), .TRI_ADDR_WIDTH(TAW),
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .CULL_BACKFACE(1)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_triangles(num_triangles),
    .idx_addr(idx_addr), .idx_data(idx_data), .vtx_addr(vtx_addr), .vtx_data(vtx_data),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .rast_rst(rast_rst), .rast_done(rast_done), .busy(busy), .done(done),
    .tri_drawn(tri_drawn), .tri_culled(tri_culled)
  );

  triangle_cull #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .CULL_BACKFACE(1)) u_cull_bf (
    .v0(cv0), .v1(cv1), .v2(cv2), .cull(cull_bf)
  );
  triangle_cull #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .CULL_BACKFACE(0)) u_cull_nbf (
    .v0(cv0), .v1(cv1), .v2(cv2), .cull(cull_nbf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories and a rasterizer that raises done rast_lat cycles after release.
  always @(posedge clk) begin
    idx_data <= idx_mem[idx_addr];
    vtx_data <= vtx_mem[vtx_addr];
    if (rast_rst) begin
      r_cnt     <= 0;
      rast_done <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1;
      if (r_cnt + 1 >= rast_lat) rast_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (prev_rst && !rast_rst) begin
      launches.push_back({x0, y0, x1, y1, x2, y2});
      low_cnt = 1;
    end else if (!rast_rst) begin
      low_cnt++;
      if ({x0, y0, x1, y1, x2, y2} !== launches[$]) stable_err++;
    end
    if (!prev_rst && rast_rst) lows.push_back(low_cnt);
    prev_rst = rast_rst;
    if (done) done_cnt++;
    if (busy && (idx_log.size() == 0 || idx_log[$] != int'(idx_addr))) idx_log.push_back(int'(idx_addr));
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack6(input int xa, ya, xb, yb, xc, yc);
    return {12'(xa), 12'(ya), 12'(xb), 12'(yb), 12'(xc), 12'(yc)};
  endfunction

  function automatic logic [71:0] launch_at(input int i);
    return (i < launches.size()) ? launches[i] : 'x;
  endfunction

  function automatic int low_at(input int i);
    return (i < lows.size()) ? lows[i] : -1;
  endfunction

  function automatic int vx(input int i);
    logic signed [VW-1:0] s;
    s = vtx_mem[i][VW-1:0];
    return int'(s);
  endfunction

  function automatic int vy(input int i);
    logic signed [VW-1:0] s;
    s = vtx_mem[i][2*VW-1:VW];
    return int'(s);
  endfunction

  function automatic bit model_cull(input int xa, ya, xb, yb, xc, yc, input bit bf);
    longint a;
    a = longint'(xb - xa) * longint'(yc - ya) - longint'(xc - xa) * longint'(yb - ya);
    if (a == 0) return 1'b1;
    if (bf && a < 0) return 1'b1;
    if (xa < 0 && xb < 0 && xc < 0) return 1'b1;
    if (ya < 0 && yb < 0 && yc < 0) return 1'b1;
    if (xa > FBW - 1 && xb > FBW - 1 && xc > FBW - 1) return 1'b1;
    if (ya > FBH - 1 && yb > FBH - 1 && yc > FBH - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_list(input int num);
    int a, b, c;
    exp_q.delete();
    exp_drawn  = 0;
    exp_culled = 0;
    for (int t = 0; t < num; t++) begin
      a = int'(idx_mem[t][7:0]);
      b = int'(idx_mem[t][15:8]);
      c = int'(idx_mem[t][23:16]);
      if (model_cull(vx(a), vy(a), vx(b), vy(b), vx(c), vy(c), 1'b1)) begin
        exp_culled++;
      end else begin
        exp_drawn++;
        exp_q.push_back(pack6(vx(a), vy(a), vx(b), vy(b), vx(c), vy(c)));
      end
    end
  endtask

  task automatic load_tri(input int t, input int xa, ya, xb, yb, xc, yc);
    vtx_mem[3*t]   = {12'(ya), 12'(xa)};
    vtx_mem[3*t+1] = {12'(yb), 12'(xb)};
    vtx_mem[3*t+2] = {12'(yc), 12'(xc)};
    idx_mem[t]     = {8'(3*t+2), 8'(3*t+1), 8'(3*t)};
  endtask

  task automatic set_cv(input int xa, ya, xb, yb, xc, yc);
    cv0 = {12'(ya), 12'(xa)};
    cv1 = {12'(yb), 12'(xb)};
    cv2 = {12'(yc), 12'(xc)};
    #1;
  endtask

  // Starts a list, optionally pokes start while busy, and waits (bounded) for done.
  task automatic run_list(input int num, input int lat, input int pulses, output int cycles);
    launches.delete();
    lows.delete();
    idx_log.delete();
    done_cnt   = 0;
    stable_err = 0;
    rast_lat   = lat;
    @(negedge clk);
    num_triangles = 9'(num);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 1;
    chk("busy_after_start", busy, 1);
    while (!done && cycles < TIMEOUT) begin
      start = (pulses > 0 && cycles >= 3 && cycles < 3 + 2 * pulses && (cycles % 2 == 1));
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    chk("list_done", done, 1);
    repeat (4) @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int nrand, lat, xs [6];
    start = 1'b0;
    num_triangles = '0;
    rstn = 1'b0;
    rast_lat = 1;
    cv0 = '0;
    cv1 = '0;
    cv2 = '0;
    for (int i = 0; i < 256; i++) begin
      idx_mem[i] = '0;
      vtx_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rast_rst", rast_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drawn", tri_drawn, 0);
    chk("rst_culled", tri_culled, 0);
    chk("rst_addrs", {idx_addr, vtx_addr}, 0);
    chk("rst_coords", {x0, y0, x1, y1, x2, y2}, 0);
    rstn = 1'b1;
    @(negedge clk);

    load_tri(0, 10, 10, 50, 10, 10, 40);
    run_list(1, 25, 0, lat_d);
    chk("single_count", launches.size(), 1);
    chk("single_coords", launch_at(0), pack6(10, 10, 50, 10, 10, 40));
    chk("single_rast_low", low_at(0), 26);
    chk("single_stable", stable_err, 0);
    chk("single_done_pulses", done_cnt, 1);
    chk("single_counts", {tri_drawn, tri_culled}, {9'd1, 9'd0});

    load_tri(0, 0, 0, 10, 10, 20, 20);
    run_list(1, 5, 0, lat_d);
    chk("collinear_launches", launches.size(), 0);
    chk("collinear_counts", {tri_drawn, tri_culled}, {9'd0, 9'd1});
    chk("collinear_done_pulses", done_cnt, 1);

    load_tri(0, 10, 10, 10, 40, 50, 10);
    run_list(1, 5, 0, lat_d);
    chk("cw_launches", launches.size(), 0);
    chk("cw_counts", {tri_drawn, tri_culled}, {9'd0, 9'd1});

    set_cv(10, 10, 10, 40, 50, 10);
    chk("unit_cw_bf1", cull_bf, 1);
    chk("unit_cw_bf0", cull_nbf, 0);
    set_cv(10, 10, 50, 10, 10, 40);
    chk("unit_ccw", {cull_bf, cull_nbf}, 2'b00);
    set_cv(0, 0, 10, 10, 20, 20);
    chk("unit_collinear", {cull_bf, cull_nbf}, 2'b11);
    set_cv(-30, 5, -10, 5, -20, 20);
    chk("unit_offscreen_left", {cull_bf, cull_nbf}, 2'b11);

    load_tri(0, -30, 5, -10, 5, -20, 20);
    load_tri(1, 200, 0, 220, 0, 210, 30);
    run_list(2, 5, 0, lat_d);
    chk("offscreen_launches", launches.size(), 0);
    chk("offscreen_counts", {tri_drawn, tri_culled}, {9'd0, 9'd2});

    load_tri(0, 10, 10, 50, 10, 10, 40);
    load_tri(1, 0, 0, 10, 10, 20, 20);
    load_tri(2, 100, 50, 150, 60, 110, 100);
    run_list(3, 25, 3, lat_d);
    chk("mixed_idx_len", idx_log.size(), 3);
    chk("mixed_idx_seq", (idx_log.size() == 3) ? idx_log[0] * 65536 + idx_log[1] * 256 + idx_log[2]
                                               : -1, 258);
    chk("mixed_counts", {tri_drawn, tri_culled}, {9'd2, 9'd1});
    chk("mixed_launch1", launch_at(1), pack6(100, 50, 150, 60, 110, 100));
    chk("mixed_rast_low", low_at(1), 26);
    chk("mixed_done_pulses", done_cnt, 1);

    run_list(0, 1, 0, lat_d);
    chk("zero_done_latency", lat_d, 2);
    chk("zero_launches", launches.size(), 0);
    chk("zero_counts", {tri_drawn, tri_culled}, 0);
    chk("zero_done_pulses", done_cnt, 1);

    load_tri(0, 10, 10, 50, 10, 10, 40);
    rast_lat = 50;
    @(negedge clk);
    num_triangles = 9'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && rast_rst; k++) @(negedge clk);
    chk("midrst_rasterizing", rast_rst, 0);
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_rast_rst", rast_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_drawn", tri_drawn, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_list(1, 4, 0, lat_d);
    chk("after_rst_launch", launch_at(0), pack6(10, 10, 50, 10, 10, 40));
    chk("after_rst_counts", {tri_drawn, tri_culled}, {9'd1, 9'd0});

    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 256; i++) begin
        vtx_mem[i] = {12'(int'($urandom_range(200)) - 40), 12'(int'($urandom_range(280)) - 60)};
      end
      nrand = int'($urandom_range(8, 1));
      for (int t = 0; t < nrand; t++) begin
        idx_mem[t] = {8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255))};
        if ($urandom_range(4) == 0) idx_mem[t][15:8] = idx_mem[t][7:0];
      end
      model_list(nrand);
      lat = int'($urandom_range(6, 1));
      run_list(nrand, lat, 1, lat_d);
      chk("rand_counts", {tri_drawn, tri_culled}, {9'(exp_drawn), 9'(exp_culled)});
      chk("rand_launch_count", launches.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        chk("rand_launch", launch_at(i), exp_q[i]);
        chk("rand_rast_low", low_at(i), lat + 1);
      end
      chk("rand_stable", stable_err, 0);
      chk("rand_done_pulses", done_cnt, 1);
    end

    for (int n = 0; n < 20; n++) begin
      for (int j = 0; j < 6; j++) xs[j] = int'($urandom_range(600)) - 200;
      set_cv(xs[0], xs[1], xs[2], xs[3], xs[4], xs[5]);
      chk("unit_rand_bf1", cull_bf, model_cull(xs[0], xs[1], xs[2], xs[3], xs[4], xs[5], 1'b1));
      chk("unit_rand_bf0", cull_nbf, model_cull(xs[0], xs[1], xs[2], xs[3], xs[4], xs[5], 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
